// File: rtl/vga_display_if.sv
// Pixel request / response bundle between the VGA timing driver, image RAM,
// recogniser and the pixel generator.
interface vga_display_if;
   logic        vga_vs;
   logic [10:0] pix_xpos;
   logic [10:0] pix_ypos;
   logic [11:0] pix_data;
   logic [9:0]  ram_addr;
   logic [7:0]  ram_rdata;
   logic        img_ready;
   logic [3:0]  result;
   logic        result_valid;
   logic        busy;

   modport master (
      output vga_vs, pix_xpos, pix_ypos, ram_rdata, img_ready, result, result_valid, busy,
      input  pix_data, ram_addr
   );

   modport slave (
      input  vga_vs, pix_xpos, pix_ypos, ram_rdata, img_ready, result, result_valid, busy,
      output pix_data, ram_addr
   );
endinterface

// File: rtl/vga_display.sv
// Pixel generator: magnified 28x28 image, 7-segment digit glyph and blinking busy square.
// pix_data follows its coordinate by one vga_clk; no backpressure, one pixel per cycle.
module vga_display #(
   parameter logic [10:0] IMG_X        = 11'd64,
   parameter logic [10:0] IMG_Y        = 11'd128,
   parameter logic [10:0] DIG_X        = 11'd400,
   parameter logic [10:0] DIG_Y        = 11'd192,
   parameter logic [5:0]  BLINK_FRAMES = 6'd30,
   parameter logic [11:0] BG_COLOR     = 12'h000,
   parameter logic [11:0] BORDER_COLOR = 12'hFFF,
   parameter logic [11:0] SEG_COLOR    = 12'h0F0,
   parameter logic [11:0] BUSY_COLOR   = 12'hF00
) (
   input logic          vga_clk,
   input logic          rst,
   vga_display_if.slave bus
);
   typedef enum logic [2:0] {REG_BG, REG_BORDER, REG_IMG, REG_SEG, REG_BUSY} region_t;

   logic        vs_d, frame_start;
   logic [3:0]  pend_digit, shown_digit;
   logic        pend_flag;
   logic [5:0]  blink_cnt;
   logic        blink_phase;
   region_t     region_d, region_q;
   logic        img_ready_q;

   logic [10:0] x, y;
   logic        in_img, in_ring, in_dig, in_busy, seg_lit, busy_lit;
   logic [4:0]  col, row;
   logic [9:0]  row10;
   logic [5:0]  u;
   logic [6:0]  v;
   logic        u_lo, u_mid, u_hi;
   logic [6:0]  seg_hit, seg_on;
   logic [3:0]  gray;

   assign x = bus.pix_xpos;
   assign y = bus.pix_ypos;
   assign frame_start = bus.vga_vs & ~vs_d;

   // Results park in pend until a frame boundary so the glyph never tears mid-frame.
   always_ff @(posedge vga_clk or negedge rst) begin
      if (!rst) begin
         vs_d        <= 1'b1;
         pend_digit  <= 4'hF;
         shown_digit <= 4'hF;
         pend_flag   <= 1'b0;
      end else begin
         vs_d <= bus.vga_vs;
         if (frame_start && pend_flag) begin
            shown_digit <= pend_digit;
            pend_flag   <= 1'b0;
         end
         if (bus.result_valid) begin
            pend_digit <= bus.result;
            pend_flag  <= 1'b1;
         end
      end
   end

   always_ff @(posedge vga_clk or negedge rst) begin
      if (!rst) begin
         blink_cnt   <= 6'd0;
         blink_phase <= 1'b1;
      end else if (!bus.busy) begin
         blink_cnt   <= 6'd0;
         blink_phase <= 1'b1;
      end else if (frame_start) begin
         if (blink_cnt == BLINK_FRAMES - 6'd1) begin
            blink_cnt   <= 6'd0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 6'd1;
         end
      end
   end

   assign in_img  = (x >= IMG_X) && (x <= IMG_X + 11'd223) &&
                    (y >= IMG_Y) && (y <= IMG_Y + 11'd223);
   assign in_ring = (x >= IMG_X - 11'd2) && (x <= IMG_X + 11'd225) &&
                    (y >= IMG_Y - 11'd2) && (y <= IMG_Y + 11'd225) && !in_img;

   // Offsets only formed inside the window, so out-of-range coordinates cannot alias.
   assign col   = in_img ? 5'((x - IMG_X) >> 3) : 5'd0;
   assign row   = in_img ? 5'((y - IMG_Y) >> 3) : 5'd0;
   assign row10 = {5'd0, row};
   assign bus.ram_addr = (in_img && rst) ?
                         (row10 << 4) + (row10 << 3) + (row10 << 2) + {5'd0, col} : 10'd0;

   assign in_dig = (x >= DIG_X) && (x < DIG_X + 11'd48) &&
                   (y >= DIG_Y) && (y < DIG_Y + 11'd96);
   assign u      = in_dig ? 6'(x - DIG_X) : 6'd0;
   assign v      = in_dig ? 7'(y - DIG_Y) : 7'd0;
   assign u_lo   = u < 6'd8;
   assign u_mid  = (u >= 6'd8) && (u < 6'd40);
   assign u_hi   = u >= 6'd40;

   // Segment order {a,b,c,d,e,f,g}.
   assign seg_hit[6] = u_mid && (v < 7'd8);
   assign seg_hit[5] = u_hi  && (v >= 7'd8)  && (v < 7'd44);
   assign seg_hit[4] = u_hi  && (v >= 7'd52) && (v < 7'd88);
   assign seg_hit[3] = u_mid && (v >= 7'd88);
   assign seg_hit[2] = u_lo  && (v >= 7'd52) && (v < 7'd88);
   assign seg_hit[1] = u_lo  && (v >= 7'd8)  && (v < 7'd44);
   assign seg_hit[0] = u_mid && (v >= 7'd44) && (v < 7'd52);

   always_comb begin
      seg_on = 7'b0000001;
      case (shown_digit)
         4'd0: seg_on = 7'b1111110;
         4'd1: seg_on = 7'b0110000;
         4'd2: seg_on = 7'b1101101;
         4'd3: seg_on = 7'b1111001;
         4'd4: seg_on = 7'b0110011;
         4'd5: seg_on = 7'b1011011;
         4'd6: seg_on = 7'b1011111;
         4'd7: seg_on = 7'b1110000;
         4'd8: seg_on = 7'b1111111;
         4'd9: seg_on = 7'b1111011;
         default: seg_on = 7'b0000001;
      endcase
   end

   assign seg_lit  = in_dig && |(seg_hit & seg_on);
   assign in_busy  = (x >= DIG_X + 11'd56) && (x < DIG_X + 11'd72) &&
                     (y >= DIG_Y + 11'd80) && (y < DIG_Y + 11'd96);
   assign busy_lit = in_busy && bus.busy && blink_phase;

   always_comb begin
      region_d = REG_BG;
      if (busy_lit)     region_d = REG_BUSY;
      else if (seg_lit) region_d = REG_SEG;
      else if (in_img)  region_d = REG_IMG;
      else if (in_ring) region_d = REG_BORDER;
   end

   // Stage 1 lines up with the RAM's registered read data.
   always_ff @(posedge vga_clk or negedge rst) begin
      if (!rst) begin
         region_q    <= REG_BG;
         img_ready_q <= 1'b0;
      end else begin
         region_q    <= region_d;
         img_ready_q <= bus.img_ready;
      end
   end

   assign gray = 4'(bus.ram_rdata >> 4);

   always_comb begin
      bus.pix_data = BG_COLOR;
      case (region_q)
         REG_IMG:    bus.pix_data = img_ready_q ? {gray, gray, gray} : 12'h888;
         REG_BORDER: bus.pix_data = BORDER_COLOR;
         REG_SEG:    bus.pix_data = SEG_COLOR;
         REG_BUSY:   bus.pix_data = BUSY_COLOR;
         default:    bus.pix_data = BG_COLOR;
      endcase
   end
endmodule

// File: tb/tb_vga_display.sv
// Randomised and directed pixel stimulus scored against a geometric reference model.
module tb_vga_display;
   logic vga_clk = 1'b0;
   logic rst     = 1'b0;

   vga_display_if bus();

   vga_display dut (
      .vga_clk (vga_clk),
      .rst     (rst),
      .bus     (bus)
   );

   always #20 vga_clk = ~vga_clk;

   logic [7:0] mem [784];
   always @(posedge vga_clk) bus.ram_rdata <= mem[bus.ram_addr];

   typedef struct {
      int          due;
      int          x;
      int          y;
      logic [11:0] exp;
   } sb_t;
   sb_t q[$];

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   always @(posedge vga_clk) cyc <= cyc + 1;

   // Reference model state
   int m_pend  = 15;
   bit m_pflag = 1'b0;
   int m_shown = 15;
   int m_n     = 0;
   bit prev_vs = 1'b1;
   bit cur_busy = 1'b0;
   bit cur_rdy  = 1'b1;
   bit cur_vs   = 1'b1;

   function automatic bit in_rect(int x, int y, int x0, int y0, int w, int h);
      return (x >= x0) && (x < x0 + w) && (y >= y0) && (y < y0 + h);
   endfunction

   function automatic logic [6:0] seg_mask(int d);
      case (d)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         9: return 7'b1111011;
         default: return 7'b0000001;
      endcase
   endfunction

   function automatic bit ref_seg(int x, int y, int d);
      int su [7] = '{8, 40, 40, 8, 0, 0, 8};
      int sv [7] = '{0, 8, 52, 88, 52, 8, 44};
      int sw [7] = '{32, 8, 8, 32, 8, 8, 32};
      int sh [7] = '{8, 36, 36, 8, 36, 36, 8};
      logic [6:0] m;
      m = seg_mask(d);
      if (!in_rect(x, y, 400, 192, 48, 96)) return 1'b0;
      for (int s = 0; s < 7; s++)
         if (m[6-s] && in_rect(x - 400, y - 192, su[s], sv[s], sw[s], sh[s])) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int ref_addr(int x, int y);
      if (in_rect(x, y, 64, 128, 224, 224)) return ((y - 128) / 8) * 28 + (x - 64) / 8;
      return 0;
   endfunction

   function automatic logic [11:0] ref_pix(int x, int y, int d, bit blit, bit rdy);
      logic [7:0] g;
      if (blit && in_rect(x, y, 456, 272, 16, 16)) return 12'hF00;
      if (ref_seg(x, y, d)) return 12'h0F0;
      if (in_rect(x, y, 64, 128, 224, 224)) begin
         g = mem[ref_addr(x, y)];
         return rdy ? {g[7:4], g[7:4], g[7:4]} : 12'h888;
      end
      if (in_rect(x, y, 62, 126, 228, 228)) return 12'hFFF;
      return 12'h000;
   endfunction

   task automatic step(input int x, input int y, input bit vs, input bit rv, input int res);
      bit fs;
      logic [11:0] e;
      @(posedge vga_clk);
      #1;
      bus.pix_xpos     = 11'(x);
      bus.pix_ypos     = 11'(y);
      bus.vga_vs       = vs;
      bus.result_valid = rv;
      bus.result       = 4'(res);
      bus.busy         = cur_busy;
      bus.img_ready    = cur_rdy;
      fs = vs && !prev_vs;
      prev_vs = vs;
      if (!cur_busy) m_n = 0;
      e = ref_pix(x, y, m_shown, cur_busy && ((m_n / 30) % 2 == 0), cur_rdy);
      q.push_back(sb_t'{cyc + 1, x, y, e});
      if (fs && cur_busy) m_n++;
      if (fs && m_pflag) begin
         m_shown = m_pend;
         m_pflag = 1'b0;
      end
      if (rv) begin
         m_pend  = res;
         m_pflag = 1'b1;
      end
      #1;
      checks++;
      if (bus.ram_addr !== 10'(ref_addr(x, y))) begin
         fails++;
         $display("FAIL ram_addr x=%0d y=%0d got=%0d exp=%0d", x, y, bus.ram_addr, ref_addr(x, y));
      end
   endtask

   task automatic frame_edge(input int x, input int y, input bit rv, input int res);
      step(0, 0, 1'b0, 1'b0, 0);
      step(x, y, 1'b1, rv, res);
   endtask

   task automatic rand_step();
      int x, y;
      bit rv;
      case ($urandom_range(0, 4))
         0: begin x = $urandom_range(58, 293);  y = $urandom_range(122, 357); end
         1: begin x = $urandom_range(396, 451); y = $urandom_range(188, 291); end
         2: begin x = $urandom_range(450, 475); y = $urandom_range(268, 292); end
         3: begin x = $urandom_range(0, 2047);  y = $urandom_range(0, 2047);  end
         default: begin x = $urandom_range(0, 799); y = $urandom_range(0, 524); end
      endcase
      if ($urandom_range(0, 7) == 0) cur_vs = !cur_vs;
      if ($urandom_range(0, 39) == 0) cur_busy = !cur_busy;
      if ($urandom_range(0, 19) == 0) cur_rdy = !cur_rdy;
      rv = ($urandom_range(0, 9) == 0);
      step(x, y, cur_vs, rv, $urandom_range(0, 15));
   endtask

   // Monitor: pops and scores each expected pixel in the cycle it becomes due.
   initial begin
      forever begin
         @(negedge vga_clk);
         while (q.size() > 0 && q[0].due <= cyc) begin
            sb_t e;
            e = q.pop_front();
            checks++;
            if (bus.pix_data !== e.exp) begin
               fails++;
               $display("FAIL pix x=%0d y=%0d got=%h exp=%h", e.x, e.y, bus.pix_data, e.exp);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 784; i++) mem[i] = 8'($urandom);
      mem[1] = 8'hA5;
      bus.vga_vs       = 1'b1;
      bus.pix_xpos     = 11'd0;
      bus.pix_ypos     = 11'd0;
      bus.result_valid = 1'b0;
      bus.result       = 4'd0;
      bus.busy         = 1'b0;
      bus.img_ready    = 1'b1;

      // Reset held: coordinates swept through the image window and digit box.
      for (int i = 0; i < 10; i++) begin
         @(posedge vga_clk);
         #1;
         bus.pix_xpos = 11'(64 + i * 30);
         bus.pix_ypos = 11'(130 + i * 20);
         @(negedge vga_clk);
         checks += 2;
         if (bus.pix_data !== 12'h000) begin
            fails++;
            $display("FAIL reset_pix got=%h exp=000", bus.pix_data);
         end
         if (bus.ram_addr !== 10'd0) begin
            fails++;
            $display("FAIL reset_addr got=%0d exp=0", bus.ram_addr);
         end
      end
      @(posedge vga_clk);
      #1 rst = 1'b1;

      // Address map, colour and border edges
      step(287, 351, 1'b1, 1'b0, 0);
      step(72, 128, 1'b1, 1'b0, 0);
      step(64, 128, 1'b1, 1'b0, 0);
      cur_rdy = 1'b0;
      step(100, 200, 1'b1, 1'b0, 0);
      cur_rdy = 1'b1;
      step(63, 138, 1'b1, 1'b0, 0);
      step(61, 138, 1'b1, 1'b0, 0);
      step(62, 126, 1'b1, 1'b0, 0);
      step(289, 353, 1'b1, 1'b0, 0);
      step(290, 200, 1'b1, 1'b0, 0);
      step(288, 200, 1'b1, 1'b0, 0);

      // Frame-synchronised digit update
      step(444, 212, 1'b1, 1'b0, 0);
      step(420, 240, 1'b1, 1'b0, 0);
      step(0, 0, 1'b1, 1'b1, 7);
      step(444, 212, 1'b1, 1'b0, 0);
      step(420, 240, 1'b1, 1'b0, 0);
      frame_edge(444, 212, 1'b0, 0);
      step(444, 212, 1'b1, 1'b0, 0);
      step(420, 240, 1'b1, 1'b0, 0);
      step(0, 0, 1'b1, 1'b1, 3);
      step(0, 0, 1'b1, 1'b1, 5);
      frame_edge(404, 212, 1'b0, 0);
      step(404, 212, 1'b1, 1'b0, 0);
      step(444, 212, 1'b1, 1'b0, 0);
      step(0, 0, 1'b1, 1'b1, 12);
      frame_edge(420, 240, 1'b0, 0);
      step(420, 240, 1'b1, 1'b0, 0);
      step(404, 212, 1'b1, 1'b0, 0);

      // Strobe coinciding with frame start lands one frame later
      step(0, 0, 1'b1, 1'b1, 8);
      frame_edge(444, 260, 1'b1, 2);
      step(444, 260, 1'b1, 1'b0, 0);
      step(420, 194, 1'b1, 1'b0, 0);
      frame_edge(444, 260, 1'b0, 0);
      step(444, 260, 1'b1, 1'b0, 0);
      step(404, 260, 1'b1, 1'b0, 0);

      // Busy blink across 135 frames, then drop mid-phase
      cur_busy = 1'b1;
      for (int f = 0; f < 135; f++) begin
         frame_edge(460, 280, 1'b0, 0);
         step(460, 280, 1'b1, 1'b0, 0);
         step(471, 287, 1'b1, 1'b0, 0);
      end
      cur_busy = 1'b0;
      step(460, 280, 1'b1, 1'b0, 0);
      step(456, 272, 1'b1, 1'b0, 0);
      cur_busy = 1'b1;
      step(460, 280, 1'b1, 1'b0, 0);
      frame_edge(465, 283, 1'b0, 0);
      step(465, 283, 1'b1, 1'b0, 0);

      for (int i = 0; i < 600; i++) rand_step();

      repeat (3) @(posedge vga_clk);
      @(negedge vga_clk);
      checks++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain got=%0d exp=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
